fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one 8-bit FIFO write port among `NUM_REQ` producers. It grants the port to one producer at a time for a bounded burst, gates every write against `fifo_full`, and returns a per-word acknowledge to the owning producer. It sits directly in front of the FIFO write port (`wr_en`/`buf_in`/`buf_full`) in the same clock domain.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 91 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    // Owner index width; a single producer still needs one bit.
    function automatic int owner_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Burst counter must hold MAX_BURST itself without wrapping.
    function automatic int burst_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request strictly after `last`, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] probe_s;
    logic             found_s;

    // Walk the ring once starting at last+1; the probe at k==NUM_REQ-1 is `last` itself.
    always_comb begin
        pick    = '0;
        idx     = last;
        probe_s = last;
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe_s = (probe_s == IDX_W'(NUM_REQ - 1)) ? '0 : probe_s + IDX_W'(1);
            if (!found_s && req[probe_s]) begin
                found_s       = 1'b1;
                pick[probe_s] = 1'b1;
                idx           = probe_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded bursts and write gating against fifo_full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ   = DEF_NUM_REQ,
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  MAX_BURST = DEF_MAX_BURST,
    localparam int OW        = owner_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [OW-1:0]             owner
);

    localparam int BW = burst_width(MAX_BURST);

    arb_state_t         state_r;
    logic [BW-1:0]      burst_cnt_r;
    logic [NUM_REQ-1:0] pick_s;
    logic [OW-1:0]      pick_idx_s;
    logic               last_word_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OW)
    ) u_pick (
        .req  (req),
        .last (owner),
        .pick (pick_s),
        .idx  (pick_idx_s)
    );

    assign last_word_s = (burst_cnt_r == BW'(MAX_BURST - 1));

    // Write strobe, per-word ack and data mux; full is gated in the same cycle.
    always_comb begin
        fifo_wr_en = 1'b0;
        ack        = '0;
        fifo_din   = '0;
        if (state_r == ST_GRANT) begin
            fifo_wr_en = req[owner] && !fifo_full;
            ack[owner] = req[owner] && !fifo_full;
            fifo_din   = req_data[owner*DATA_W +: DATA_W];
        end else begin
            fifo_wr_en = 1'b0;
        end
    end

    // Grant FSM and burst counter; owner is kept across release so rotation resumes after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gnt         <= '0;
            owner       <= OW'(NUM_REQ - 1);
            burst_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        state_r     <= ST_GRANT;
                        gnt         <= pick_s;
                        owner       <= pick_idx_s;
                        burst_cnt_r <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!req[owner] || (fifo_wr_en && last_word_s)) begin
                        state_r <= ST_IDLE;
                        gnt     <= '0;
                    end
                    if (fifo_wr_en) begin
                        burst_cnt_r <= burst_cnt_r + BW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter with a write-order scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
    } word_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_din;
    logic [1:0]                owner;

    word_t      exp_q[$];
    logic [7:0] prod_q[NUM_REQ][$];
    int         grant_log[$];
    int         exp_order[$];
    int         wait_cnt[NUM_REQ];
    int         burst_words;
    bit         use_sb;
    bit         last_wrote;
    int         n_assert;
    int         n_fail;
    int         cyc;

    bit t1_wr [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit t1_g  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = (prod_q[i].size() != 0);
            req_data[i*DATA_W +: DATA_W] = (prod_q[i].size() != 0) ? prod_q[i][0] : 8'h00;
        end
    endtask

    task automatic load(input int i, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            prod_q[i].push_back(base + 8'(k));
            exp_q.push_back('{data: base + 8'(k), idx: 2'(i)});
        end
    endtask

    // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
    task automatic tick();
        logic [NUM_REQ-1:0] acked;
        logic [NUM_REQ-1:0] req_seen;
        logic [NUM_REQ-1:0] gnt_before;
        word_t              e;
        int                 idx;
        @(negedge clk);
        acked      = ack;
        req_seen   = req;
        gnt_before = gnt;
        last_wrote = fifo_wr_en;
        idx        = 0;
        check("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'd0);
        if (fifo_wr_en) begin
            check("ack_onehot", 32'($onehot(ack)), 32'd1);
            for (int i = 0; i < NUM_REQ; i++) if (ack[i]) idx = i;
            if (prod_q[idx].size() != 0) check("din_vs_producer", 32'(fifo_din), 32'(prod_q[idx][0]));
            else check("write_from_empty_producer", 32'(idx), 32'hFFFF_FFFF);
            if (use_sb) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(fifo_din), 32'(e.data));
                    check("sb_owner", 32'(idx), 32'(e.idx));
                end else begin
                    check("sb_unexpected_write", 32'(fifo_din), 32'hFFFF_FFFF);
                end
            end
            burst_words++;
            check("burst_len", 32'(burst_words <= MAX_BURST), 32'd1);
        end else begin
            check("ack_idle", 32'(ack), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (acked[i] && prod_q[i].size() != 0) void'(prod_q[i].pop_front());
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (gnt_before == '0 && gnt != '0) begin
            grant_log.push_back(int'(owner));
            burst_words = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) wait_cnt[i] = 0;
                else if (req_seen[i]) begin
                    wait_cnt[i]++;
                    check("fair_wait", 32'(wait_cnt[i] <= NUM_REQ - 1), 32'd1);
                end else wait_cnt[i] = 0;
            end
        end
        drive_inputs();
    endtask

    task automatic run_until_empty(input int max_ticks, output int used);
        used = 0;
        while (exp_q.size() != 0 && used < max_ticks) begin
            tick();
            used++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_log();
        check("grant_count", 32'(grant_log.size()), 32'(exp_order.size()));
        for (int k = 0; k < exp_order.size() && k < grant_log.size(); k++)
            check("grant_order", 32'(grant_log[k]), 32'(exp_order[k]));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            prod_q[i].delete();
            wait_cnt[i] = 0;
        end
        exp_q.delete();
        burst_words = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        use_sb   = 1'b1;
        rst      = 1'b0;
        #2;
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_owner", 32'(owner), 32'd3);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_din", 32'(fifo_din), 32'd0);

        // Single requester: two full bursts separated by one bubble
        grant_log.delete();
        load(0, 8'hA1, 8);
        drive_inputs();
        for (int t = 0; t < 11; t++) begin
            tick();
            check("t1_wr", 32'(last_wrote), 32'(t1_wr[t]));
            check("t1_gnt", 32'(gnt), t1_g[t] ? 32'd1 : 32'd0);
        end
        check("t1_owner", 32'(owner), 32'd0);

        // All requesters active: order 0,1,2,3,0 with 4 words each
        do_reset();
        grant_log.delete();
        load(0, 8'h10, 4);
        load(1, 8'h20, 4);
        load(2, 8'h30, 4);
        load(3, 8'h40, 4);
        load(0, 8'h18, 4);
        drive_inputs();
        run_until_empty(60, cyc);
        check("t2_cycles", 32'(cyc), 32'd25);
        exp_order = '{0, 1, 2, 3, 0};
        check_log();

        // Early release by requester 2 after two words
        grant_log.delete();
        load(2, 8'h31, 2);
        drive_inputs();
        tick();
        check("t3_gnt2", 32'(gnt), 32'h4);
        load(3, 8'h41, 1);
        load(1, 8'h51, 1);
        drive_inputs();
        tick();
        tick();
        check("t3_wr2", 32'(last_wrote), 32'd1);
        check("t3_gnt_held", 32'(gnt), 32'h4);
        tick();
        check("t3_no_wr", 32'(last_wrote), 32'd0);
        check("t3_gnt_clear", 32'(gnt), 32'd0);
        check("t3_owner", 32'(owner), 32'd2);
        run_until_empty(20, cyc);
        tick();
        tick();
        exp_order = '{2, 3, 1};
        check_log();

        // Full stall after one word
        load(0, 8'hC1, 4);
        drive_inputs();
        tick();
        check("t4_gnt", 32'(gnt), 32'h1);
        tick();
        check("t4_first_wr", 32'(last_wrote), 32'd1);
        fifo_full = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("t4_stall_wr", 32'(last_wrote), 32'd0);
            check("t4_stall_gnt", 32'(gnt), 32'h1);
            check("t4_stall_cnt", 32'(dut.burst_cnt_r), 32'd1);
        end
        fifo_full = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("t4_resume_wr", 32'(last_wrote), 32'd1);
        end
        check("t4_release", 32'(gnt), 32'd0);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during the second word
        tick();
        load(0, 8'hE1, 4);
        drive_inputs();
        tick();
        tick();
        check("t5_first_wr", 32'(last_wrote), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_gnt", 32'(gnt), 32'd0);
        check("t5_rst_ack", 32'(ack), 32'd0);
        check("t5_rst_wr", 32'(fifo_wr_en), 32'd0);
        do_reset();
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) load(i, 8'hF0 + 8'(i), 1);
        drive_inputs();
        run_until_empty(40, cyc);
        exp_order = '{0, 1, 2, 3};
        check_log();

        // Random soak: invariants only, order checked against producer heads
        use_sb = 1'b0;
        for (int t = 0; t < 10000; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prod_q[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    for (int k = 0; k < int'($urandom_range(1, 6)); k++) prod_q[i].push_back(8'($urandom));
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            drive_inputs();
            tick();
        end
        fifo_full = 1'b0;
        drive_inputs();
        cyc = 0;
        while ((prod_q[0].size() + prod_q[1].size() + prod_q[2].size() + prod_q[3].size()) != 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("soak_drain", 32'(prod_q[0].size() + prod_q[1].size() + prod_q[2].size() + prod_q[3].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
